// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16x16->32 multiply sequencer sharing the core ALU
module alu_mul_seq #(
  parameter int DATA_W     = 16,
  parameter int ALU_FUNC_W = 4,
  parameter int FR_FLAG_W  = 4,
  parameter logic [ALU_FUNC_W-1:0] ALU_ADD = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     src_a,
  input  logic [DATA_W-1:0]     src_b,
  input  logic [DATA_W-1:0]     core_a,
  input  logic [DATA_W-1:0]     core_b,
  input  logic [ALU_FUNC_W-1:0] core_func,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0]     alu_y,
  input  logic [FR_FLAG_W-1:0]  alu_flags,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     prod_hi,
  output logic [DATA_W-1:0]     prod_lo,
  output logic [FR_FLAG_W-1:0]  mul_flags
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mcand, acc_hi, acc_lo;
  logic [DATA_W-1:0] prod_hi_q, prod_lo_q;
  logic [CNT_W-1:0]  cnt;
  logic              last_iter;
  logic              unused_flags;

  assign last_iter    = (cnt == CNT_W'(DATA_W - 1));
  assign unused_flags = ^{alu_flags[FR_FLAG_W-1:2], alu_flags[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    alu_a     = core_a;
    alu_b     = core_b;
    alu_func  = core_func;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        alu_a    = acc_hi;
        alu_b    = acc_lo[0] ? mcand : '0;
        alu_func = ALU_ADD;
        busy     = 1'b1;
        if (abort)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ALU carry becomes the new MSB of acc_hi so the partial sum never overflows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= src_a;
            acc_lo <= src_b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            {acc_hi, acc_lo} <= {alu_flags[1], alu_y, acc_lo[DATA_W-1:1]};
            cnt              <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!abort) begin
            prod_hi_q <= acc_hi;
            prod_lo_q <= acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Product is visible during the done cycle itself, then held in prod_*_q
  assign prod_hi   = done ? acc_hi : prod_hi_q;
  assign prod_lo   = done ? acc_lo : prod_lo_q;
  assign mul_flags = {prod_hi[DATA_W-1], ~|{prod_hi, prod_lo}, 1'b0, |prod_hi};

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - self-checking bench for alu_mul_seq with a behavioural ALU
module tb_alu_mul_seq;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [DW-1:0] src_a = '0, src_b = '0, core_a = '0, core_b = '0;
  logic [FW-1:0] core_func = ALU_SUB;
  logic [DW-1:0] alu_a, alu_b, alu_y, prod_hi, prod_lo;
  logic [FW-1:0] alu_func, alu_flags, mul_flags;
  logic          busy, done;
  logic [DW:0]   alu_wide;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.DATA_W(DW), .ALU_FUNC_W(FW), .FR_FLAG_W(FW), .ALU_ADD(ALU_ADD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .src_a(src_a), .src_b(src_b), .core_a(core_a), .core_b(core_b), .core_func(core_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_y(alu_y), .alu_flags(alu_flags),
    .busy(busy), .done(done), .prod_hi(prod_hi), .prod_lo(prod_lo), .mul_flags(mul_flags)
  );

  // Behavioural ALU: flags are {N, Z, C, V}
  always_comb begin
    case (alu_func)
      ALU_ADD: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      default: alu_wide = {1'b0, alu_a & alu_b};
    endcase
    alu_y     = alu_wide[DW-1:0];
    alu_flags = {alu_wide[DW-1], alu_wide[DW-1:0] == '0, alu_wide[DW], 1'b0};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_flags(input logic [31:0] p);
    ref_flags = {p >= 32'h8000_0000, p == 32'd0, 1'b0, p > 32'h0000_FFFF};
  endfunction

  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input bit pulse_start, input string tag);
    logic [31:0] exp_p;
    int n;
    bit seen;
    exp_p = 32'(a) * 32'(b);
    src_a = a;
    src_b = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    core_a = 16'($urandom);
    check({tag, "_run_busy"}, busy, 1);
    check({tag, "_run_func"}, alu_func, ALU_ADD);
    check({tag, "_run_a"}, alu_a, 0);
    n = 0;
    seen = 0;
    while (n < 40 && !seen) begin
      if (done) seen = 1;
      else begin
        start = (pulse_start && n == 4);
        tick();
        n++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, seen ? n + 1 : 999, DW + 1);
    check({tag, "_product"}, {prod_hi, prod_lo}, exp_p);
    check({tag, "_flags"}, mul_flags, ref_flags(exp_p));
    check({tag, "_done_passthru"}, alu_a, core_a);
    tick();
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    check({tag, "_held"}, {prod_hi, prod_lo, mul_flags}, {exp_p, ref_flags(exp_p)});
  endtask

  initial begin
    int extra_done;
    logic [31:0] prev_p;

    tick();
    tick();
    check("reset_state", {busy, done, prod_hi, prod_lo, mul_flags}, {2'b00, 32'd0, 4'b0100});
    rst_n = 1'b1;
    tick();

    core_a = 16'h1234;
    core_b = 16'h0001;
    core_func = ALU_SUB;
    #1;
    check("idle_passthru", {alu_a, alu_b, alu_func, busy}, {16'h1234, 16'h0001, ALU_SUB, 1'b0});

    run_mul(16'd3, 16'd5, 0, "m3x5");
    run_mul(16'hFFFF, 16'hFFFF, 0, "mffff");
    run_mul(16'd0, 16'hABCD, 1, "m0_restart");
    extra_done = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (done) extra_done++;
    end
    check("no_restart_done", extra_done, 0);

    for (int i = 0; i < 6; i++) run_mul(16'($urandom), 16'($urandom), 0, "rand");
    run_mul(16'h1234, 16'h0010, 0, "m_pre_abort");
    prev_p = 32'h0001_2340;

    // Abort in the eighth RUN cycle
    src_a = 16'h1111;
    src_b = 16'h2222;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, done}, 2'b00);
    check("abort_retain", {prod_hi, prod_lo}, prev_p);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) extra_done++;
    end
    check("abort_no_done", extra_done, 0);
    run_mul(16'd7, 16'd9, 0, "m7x9");

    // Asynchronous reset in the fifth RUN cycle
    src_a = 16'hBEEF;
    src_b = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    core_a = 16'h5A5A;
    core_b = 16'hA5A5;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, prod_hi, prod_lo, mul_flags}, {2'b00, 32'd0, 4'b0100});
    check("async_reset_alu", {alu_a, alu_b, alu_func}, {16'h5A5A, 16'hA5A5, ALU_SUB});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_mul(16'd2, 16'd2, 0, "m2x2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
